// File: rtl/controlador_de_partida.sv
// Match sequencer for a 5x7 battleship board: counts ship cells, validates shots, drives the attack manager.
// Define TIRO_EXTRA_EN so that hits do not consume attempts (only misses decrement tentativas).
module controlador_de_partida #(
  parameter int MAX_TENTATIVAS = 15,
  parameter int PULSO_CICLOS   = 2
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       iniciar,
  input  logic       confirmar,
  input  logic [2:0] coordColuna,
  input  logic [2:0] coordLinha,
  input  logic [6:0] mapa0,
  input  logic [6:0] mapa1,
  input  logic [6:0] mapa2,
  input  logic [6:0] mapa3,
  input  logic [6:0] mapa4,
  output logic       enable_ataque,
  output logic       confirmar_ataque,
  output logic [2:0] colAtaque,
  output logic [2:0] linAtaque,
  output logic [5:0] acertos,
  output logic [5:0] tentativas,
  output logic       erro,
  output logic       vitoria,
  output logic       derrota,
  output logic       ocupado
);

  // state   | meaning
  // OCIOSO  | idle, attack manager disabled, waiting for iniciar
  // CONTA   | scanning the 35 map cells to count ship cells
  // AGUARDA | waiting for a shot (confirmar) or an abort (iniciar)
  // VALIDA  | range and repeat check of the captured coordinates
  // ATACA   | confirmar_ataque pulse to the attack manager
  // AVALIA  | scoring the shot, deciding win/loss/continue
  // VITORIA | match won, board kept visible
  // DERROTA | match lost, board kept visible
  typedef enum logic [2:0] {
    OCIOSO, CONTA, AGUARDA, VALIDA, ATACA, AVALIA, VITORIA, DERROTA
  } estado_t;

  localparam logic [5:0] TENT_INI  = 6'(MAX_TENTATIVAS);
  localparam logic [3:0] PULSO_INI = 4'(PULSO_CICLOS - 1);

  estado_t     estado_q;
  logic        iniciar_q, confirmar_q;
  logic [34:0] mask_q;
  logic [5:0]  total_q, idx_q;
  logic [3:0]  pulso_q;
  logic        enable_q, conf_atq_q, erro_q, vit_q, der_q, ocupado_q;
  logic [2:0]  col_q, lin_q;
  logic [5:0]  acertos_q, tent_q;

  logic [34:0] mapa_vet;
  logic        iniciar_ev, confirmar_ev;
  logic        coord_ok, acerto;
  logic [5:0]  cel_tiro, cel_sel;
  logic [5:0]  total_d, acertos_d, tent_dec, tent_d;

  assign mapa_vet     = {mapa4, mapa3, mapa2, mapa1, mapa0};
  assign iniciar_ev   = iniciar & ~iniciar_q;
  assign confirmar_ev = confirmar & ~confirmar_q;

  // Out-of-range coordinates are steered to cell 0 so no index ever leaves the board.
  assign coord_ok = (col_q <= 3'd4) && (lin_q <= 3'd6);
  assign cel_tiro = ({3'b000, col_q} * 6'd7) + {3'b000, lin_q};
  assign cel_sel  = coord_ok ? cel_tiro : 6'd0;
  assign acerto   = mapa_vet[cel_sel];

  assign total_d   = total_q + {5'b00000, mapa_vet[idx_q]};
  assign acertos_d = (acerto && (acertos_q != 6'd63)) ? acertos_q + 6'd1 : acertos_q;
  assign tent_dec  = (tent_q == 6'd0) ? 6'd0 : tent_q - 6'd1;

  always_comb begin
    tent_d = tent_dec;
`ifdef TIRO_EXTRA_EN
    if (acerto) tent_d = tent_q;
`endif
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      estado_q    <= OCIOSO;
      // Loaded with the live levels so a button held through reset does not fire.
      iniciar_q   <= iniciar;
      confirmar_q <= confirmar;
      mask_q      <= '0;
      total_q     <= '0;
      idx_q       <= '0;
      pulso_q     <= '0;
      enable_q    <= 1'b0;
      conf_atq_q  <= 1'b0;
      erro_q      <= 1'b0;
      vit_q       <= 1'b0;
      der_q       <= 1'b0;
      ocupado_q   <= 1'b0;
      col_q       <= '0;
      lin_q       <= '0;
      acertos_q   <= '0;
      tent_q      <= '0;
    end else begin
      iniciar_q   <= iniciar;
      confirmar_q <= confirmar;
      erro_q      <= 1'b0;
      ocupado_q   <= 1'b1;
      case (estado_q)
        OCIOSO: begin
          enable_q <= 1'b0;
          if (iniciar_ev) begin
            estado_q  <= CONTA;
            total_q   <= '0;
            idx_q     <= '0;
            mask_q    <= '0;
            acertos_q <= '0;
            tent_q    <= TENT_INI;
          end
        end
        CONTA: begin
          total_q <= total_d;
          if (idx_q == 6'd33) enable_q <= 1'b1;
          if (idx_q == 6'd34) begin
            ocupado_q <= 1'b0;
            if (total_d == 6'd0) begin
              estado_q <= VITORIA;
              vit_q    <= 1'b1;
            end else begin
              estado_q <= AGUARDA;
            end
          end else begin
            idx_q <= idx_q + 6'd1;
          end
        end
        AGUARDA: begin
          ocupado_q <= 1'b0;
          if (iniciar_ev) begin
            estado_q  <= OCIOSO;
            enable_q  <= 1'b0;
            ocupado_q <= 1'b1;
          end else if (confirmar_ev) begin
            estado_q  <= VALIDA;
            col_q     <= coordColuna;
            lin_q     <= coordLinha;
            ocupado_q <= 1'b1;
          end
        end
        VALIDA: begin
          if (!coord_ok || mask_q[cel_sel]) begin
            estado_q  <= AGUARDA;
            erro_q    <= 1'b1;
            ocupado_q <= 1'b0;
          end else begin
            estado_q        <= ATACA;
            mask_q[cel_sel] <= 1'b1;
            conf_atq_q      <= 1'b1;
            pulso_q         <= PULSO_INI;
          end
        end
        ATACA: begin
          if (pulso_q == 4'd0) begin
            conf_atq_q <= 1'b0;
            estado_q   <= AVALIA;
          end else begin
            pulso_q <= pulso_q - 4'd1;
          end
        end
        AVALIA: begin
          acertos_q <= acertos_d;
          tent_q    <= tent_d;
          ocupado_q <= 1'b0;
          // Completing the board wins even when it was the last attempt.
          if (acertos_d == total_q) begin
            estado_q <= VITORIA;
            vit_q    <= 1'b1;
          end else if (tent_d == 6'd0) begin
            estado_q <= DERROTA;
            der_q    <= 1'b1;
          end else begin
            estado_q <= AGUARDA;
          end
        end
        VITORIA, DERROTA: begin
          ocupado_q <= 1'b0;
          if (iniciar_ev) begin
            estado_q  <= OCIOSO;
            vit_q     <= 1'b0;
            der_q     <= 1'b0;
            enable_q  <= 1'b0;
            ocupado_q <= 1'b1;
          end
        end
        default: estado_q <= OCIOSO;
      endcase
    end
  end

  assign enable_ataque    = enable_q;
  assign confirmar_ataque = conf_atq_q;
  assign colAtaque        = col_q;
  assign linAtaque        = lin_q;
  assign acertos          = acertos_q;
  assign tentativas       = tent_q;
  assign erro             = erro_q;
  assign vitoria          = vit_q;
  assign derrota          = der_q;
  assign ocupado          = ocupado_q;

endmodule

// File: tb/tb_controlador_de_partida.sv
// Directed bench for controlador_de_partida: three instances (15, 3 and 8 attempts) share one stimulus stream.
// Expected values follow TIRO_EXTRA_EN when the macro is defined for the build.
module tb_controlador_de_partida;

`ifdef TIRO_EXTRA_EN
  localparam bit EXTRA = 1'b1;
`else
  localparam bit EXTRA = 1'b0;
`endif

  logic       clock = 1'b0;
  logic       reset_n;
  logic       iniciar, confirmar;
  logic [2:0] coordColuna, coordLinha;
  logic [6:0] mapa0, mapa1, mapa2, mapa3, mapa4;

  logic       en_w [3];
  logic       ca_w [3];
  logic       erro_w [3];
  logic       vit_w [3];
  logic       der_w [3];
  logic       ocup_w [3];
  logic [2:0] col_w [3];
  logic [2:0] lin_w [3];
  logic [5:0] ac_w [3];
  logic [5:0] ten_w [3];

  int n_checks = 0;
  int n_fail   = 0;
  int n_ca [3];
  int n_erro, n_coord_bad, n_conta, n_en;

  always #5 clock = ~clock;

  controlador_de_partida #(.MAX_TENTATIVAS(15), .PULSO_CICLOS(2)) dut15 (
    .clock(clock), .reset_n(reset_n), .iniciar(iniciar), .confirmar(confirmar),
    .coordColuna(coordColuna), .coordLinha(coordLinha),
    .mapa0(mapa0), .mapa1(mapa1), .mapa2(mapa2), .mapa3(mapa3), .mapa4(mapa4),
    .enable_ataque(en_w[0]), .confirmar_ataque(ca_w[0]), .colAtaque(col_w[0]), .linAtaque(lin_w[0]),
    .acertos(ac_w[0]), .tentativas(ten_w[0]), .erro(erro_w[0]), .vitoria(vit_w[0]),
    .derrota(der_w[0]), .ocupado(ocup_w[0]));

  controlador_de_partida #(.MAX_TENTATIVAS(3), .PULSO_CICLOS(2)) dut3 (
    .clock(clock), .reset_n(reset_n), .iniciar(iniciar), .confirmar(confirmar),
    .coordColuna(coordColuna), .coordLinha(coordLinha),
    .mapa0(mapa0), .mapa1(mapa1), .mapa2(mapa2), .mapa3(mapa3), .mapa4(mapa4),
    .enable_ataque(en_w[1]), .confirmar_ataque(ca_w[1]), .colAtaque(col_w[1]), .linAtaque(lin_w[1]),
    .acertos(ac_w[1]), .tentativas(ten_w[1]), .erro(erro_w[1]), .vitoria(vit_w[1]),
    .derrota(der_w[1]), .ocupado(ocup_w[1]));

  controlador_de_partida #(.MAX_TENTATIVAS(8), .PULSO_CICLOS(2)) dut8 (
    .clock(clock), .reset_n(reset_n), .iniciar(iniciar), .confirmar(confirmar),
    .coordColuna(coordColuna), .coordLinha(coordLinha),
    .mapa0(mapa0), .mapa1(mapa1), .mapa2(mapa2), .mapa3(mapa3), .mapa4(mapa4),
    .enable_ataque(en_w[2]), .confirmar_ataque(ca_w[2]), .colAtaque(col_w[2]), .linAtaque(lin_w[2]),
    .acertos(ac_w[2]), .tentativas(ten_w[2]), .erro(erro_w[2]), .vitoria(vit_w[2]),
    .derrota(der_w[2]), .ocupado(ocup_w[2]));

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic set_map_test();
    mapa0 = 7'b1110001; mapa1 = 7'b0100000; mapa2 = 7'b0; mapa3 = 7'b0; mapa4 = 7'b1110000;
  endtask

  task automatic do_reset();
    reset_n = 1'b0; iniciar = 1'b0; confirmar = 1'b0; coordColuna = '0; coordLinha = '0;
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    repeat (2) @(negedge clock);
  endtask

  task automatic pulse_ini();
    @(negedge clock); iniciar = 1'b1;
    @(negedge clock); iniciar = 1'b0;
    repeat (2) @(negedge clock);
  endtask

  // Starts a match and counts samples with ocupado high until the scan ends.
  task automatic start_match();
    bit timeout;
    timeout = 1'b1;
    n_conta = 0; n_en = 0;
    @(negedge clock); iniciar = 1'b1;
    for (int i = 0; i < 80; i++) begin
      @(negedge clock);
      iniciar = 1'b0;
      if (!ocup_w[0]) begin
        timeout = 1'b0;
        break;
      end
      n_conta++;
      if (en_w[0]) n_en++;
    end
    check_val("start_timeout", timeout, 0);
  endtask

  task automatic shoot(input logic [2:0] c, input logic [2:0] r);
    @(negedge clock);
    coordColuna = c; coordLinha = r; confirmar = 1'b1;
    for (int k = 0; k < 3; k++) n_ca[k] = 0;
    n_erro = 0; n_coord_bad = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      confirmar = 1'b0;
      coordColuna = 3'd3; coordLinha = 3'd2;
      for (int k = 0; k < 3; k++) if (ca_w[k]) n_ca[k]++;
      if (ca_w[0] && (col_w[0] != c || lin_w[0] != r)) n_coord_bad++;
      if (erro_w[0]) n_erro++;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    set_map_test();
    reset_n = 1'b0; iniciar = 1'b0; confirmar = 1'b0; coordColuna = '0; coordLinha = '0;
    repeat (2) @(negedge clock);
    check_val("rst_enable", en_w[0], 0);
    check_val("rst_conf_ataque", ca_w[0], 0);
    check_val("rst_col_lin", {col_w[0], lin_w[0]}, 0);
    check_val("rst_acertos", ac_w[0], 0);
    check_val("rst_tentativas", ten_w[0], 0);
    check_val("rst_flags", {erro_w[0], vit_w[0], der_w[0], ocup_w[0]}, 0);
    reset_n = 1'b1;
    repeat (2) @(negedge clock);

    // Match A: counting, hits, misses, rejected shots
    start_match();
    check_val("conta_cycles", n_conta, 35);
    check_val("conta_enable_last", n_en, 1);
    check_val("aguarda_tent15", ten_w[0], 15);
    check_val("aguarda_tent3", ten_w[1], 3);
    check_val("aguarda_enable", en_w[0], 1);
    check_val("aguarda_acertos", ac_w[0], 0);

    shoot(3'd0, 3'd0);
    check_val("hit00_pulse", n_ca[0], 2);
    check_val("hit00_coord", n_coord_bad, 0);
    check_val("hit00_erro", n_erro, 0);
    check_val("hit00_acertos", ac_w[0], 1);
    check_val("hit00_tent", ten_w[0], EXTRA ? 15 : 14);
    check_val("hit00_tent8", ten_w[2], EXTRA ? 8 : 7);

    shoot(3'd2, 3'd3);
    check_val("miss23_pulse", n_ca[0], 2);
    check_val("miss23_acertos", ac_w[0], 1);
    check_val("miss23_tent", ten_w[0], EXTRA ? 14 : 13);
    check_val("miss23_tent3", ten_w[1], EXTRA ? 2 : 1);

    shoot(3'd0, 3'd0);
    check_val("repeat_erro", n_erro, 1);
    check_val("repeat_pulse", n_ca[0], 0);
    check_val("repeat_tent", ten_w[0], EXTRA ? 14 : 13);
    shoot(3'd5, 3'd0);
    check_val("col5_erro", n_erro, 1);
    check_val("col5_pulse", n_ca[0], 0);
    shoot(3'd0, 3'd7);
    check_val("lin7_erro", n_erro, 1);
    check_val("lin7_tent", ten_w[0], EXTRA ? 14 : 13);
    check_val("lin7_acertos", ac_w[0], 1);

    // iniciar and confirmar edges together: abort wins, no shot
    @(negedge clock);
    iniciar = 1'b1; confirmar = 1'b1; coordColuna = 3'd1; coordLinha = 3'd0;
    n_ca[0] = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clock);
      iniciar = 1'b0; confirmar = 1'b0;
      if (ca_w[0]) n_ca[0]++;
    end
    check_val("abort_no_pulse", n_ca[0], 0);
    check_val("abort_enable", en_w[0], 0);

    // Match B: three misses exhaust the 3-attempt instance
    do_reset();
    start_match();
    shoot(3'd2, 3'd0);
    shoot(3'd2, 3'd1);
    check_val("loss2_derrota3", der_w[1], 0);
    check_val("loss2_tent3", ten_w[1], 1);
    shoot(3'd2, 3'd2);
    check_val("loss3_derrota3", der_w[1], 1);
    check_val("loss3_tent3", ten_w[1], 0);
    check_val("loss3_vitoria3", vit_w[1], 0);
    check_val("loss3_derrota15", der_w[0], 0);
    check_val("loss3_tent15", ten_w[0], 12);
    shoot(3'd3, 3'd0);
    check_val("loss_ignored_pulse3", n_ca[1], 0);
    check_val("loss_other_pulse15", n_ca[0], 2);
    check_val("loss_ignored_tent3", ten_w[1], 0);
    check_val("loss_held_enable3", en_w[1], 1);
    pulse_ini();
    check_val("loss_restart_enable3", en_w[1], 0);
    check_val("loss_restart_derrota3", der_w[1], 0);
    check_val("loss_restart_enable15", en_w[0], 0);

    // Match C: sink all eight ship cells
    do_reset();
    start_match();
    shoot(3'd0, 3'd0);
    shoot(3'd0, 3'd4);
    shoot(3'd0, 3'd5);
    shoot(3'd0, 3'd6);
    shoot(3'd1, 3'd5);
    shoot(3'd4, 3'd4);
    shoot(3'd4, 3'd5);
    check_val("win7_vitoria8", vit_w[2], 0);
    check_val("win7_acertos8", ac_w[2], 7);
    check_val("win7_tent8", ten_w[2], EXTRA ? 8 : 1);
    shoot(3'd4, 3'd6);
    check_val("win8_vitoria8", vit_w[2], 1);
    check_val("win8_derrota8", der_w[2], 0);
    check_val("win8_tent8", ten_w[2], EXTRA ? 8 : 0);
    check_val("win8_acertos8", ac_w[2], 8);
    check_val("win8_vitoria15", vit_w[0], 1);
    check_val("win8_tent15", ten_w[0], EXTRA ? 15 : 7);
    check_val("win8_dut3_vitoria", vit_w[1], EXTRA ? 1 : 0);
    check_val("win8_dut3_derrota", der_w[1], EXTRA ? 0 : 1);
    check_val("win8_dut3_acertos", ac_w[1], EXTRA ? 8 : 3);
    shoot(3'd2, 3'd0);
    check_val("win_ignored_pulse", n_ca[2], 0);
    check_val("win_held_enable", en_w[2], 1);
    check_val("win_held_vitoria", vit_w[2], 1);

    // Reset asserted while the attack pulse is high
    do_reset();
    start_match();
    @(negedge clock);
    coordColuna = 3'd1; coordLinha = 3'd1; confirmar = 1'b1;
    begin
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < 10; i++) begin
        @(negedge clock);
        confirmar = 1'b0;
        if (ca_w[0]) begin
          seen = 1'b1;
          break;
        end
      end
      check_val("midpulse_seen", seen, 1);
    end
    #2 reset_n = 1'b0;
    #1;
    check_val("midpulse_conf_ataque", ca_w[0], 0);
    check_val("midpulse_enable", en_w[0], 0);
    check_val("midpulse_ocupado", ocup_w[0], 0);

    // Held iniciar through reset must not start; then an empty map wins after the scan
    mapa0 = '0; mapa1 = '0; mapa2 = '0; mapa3 = '0; mapa4 = '0;
    iniciar = 1'b1;
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    repeat (45) @(negedge clock);
    check_val("held_ini_enable", en_w[0], 0);
    check_val("held_ini_vitoria", vit_w[0], 0);
    iniciar = 1'b0;
    repeat (2) @(negedge clock);
    start_match();
    check_val("empty_conta_cycles", n_conta, 35);
    check_val("empty_vitoria", vit_w[0], 1);
    check_val("empty_derrota", der_w[0], 0);
    check_val("empty_enable", en_w[0], 1);
    check_val("empty_acertos", ac_w[0], 0);
    check_val("empty_tent", ten_w[0], 15);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/controlador_de_partida.md
Name: controlador_de_partida

Overview:
- Sequencing FSM for one battleship match on the 5-column x 7-row board.
- Counts the ship cells in the final map, then accepts player coordinates and rejects invalid or repeated shots.
- Drives the attack manager's enable/confirm pins (enable_ataque, confirmar_ataque) and tracks hits and remaining attempts until win or loss.
- Sits between the button/switch front end and the attack manager. Its outputs feed the display logic.

Parameters:
- MAX_TENTATIVAS, 15: attempts per match; legal range 1..63.
- PULSO_CICLOS, 2: width of the confirmar_ataque pulse in clocks; legal range 1..15.

Ports:
- clock  input  1  system clock; all state changes on rising edge.
- reset_n  input  1  asynchronous active-low reset.
- iniciar  input  1  level; a rising edge starts a new match.
- confirmar  input  1  level from debounced button; a rising edge requests a shot.
- coordColuna  input  3  column selection; valid 0..4.
- coordLinha  input  3  row selection; valid 0..6.
- mapa0..mapa4  input  7 each  final map per column; bit index = row; 1 = ship cell.
- enable_ataque  output  1  to attack manager enable; 0 clears its matrices.
- confirmar_ataque  output  1  to attack manager confirmar.
- colAtaque, linAtaque  output  3 each  registered coordinates to the attack manager.
- acertos  output  6  hits so far.
- tentativas  output  6  attempts remaining.
- erro  output  1  one-clock pulse on a rejected shot.
- vitoria, derrota  output  1 each  match result, held.
- ocupado  output  1  high in every state except AGUARDA, VITORIA and DERROTA.

Behaviour:
- Reset (async, reset_n=0) values:
  - state OCIOSO; all outputs 0; tentativas=0.
  - internal attacked mask (35 bits) cleared; total_alvos=0; scan index=0.
  - Both edge-detect registers are loaded with the current input levels, so a button held through reset does not fire.
- Edge detection is synchronous: a 1-clock delayed copy of each input; edge = input & ~delayed.
- OCIOSO:
  - enable_ataque=0.
  - iniciar edge -> CONTA. On entry: total_alvos=0, index=0, attacked mask cleared, acertos=0, tentativas=MAX_TENTATIVAS.
- CONTA:
  - One cell per clock, index 0..34; cell = column*7 + row. total_alvos += map bit.
  - Takes exactly 35 clocks.
  - enable_ataque rises to 1 on the last CONTA clock.
  - Exit to AGUARDA, or directly to VITORIA if total_alvos==0.
- AGUARDA:
  - confirmar edge -> VALIDA. coordColuna/coordLinha are captured into colAtaque/linAtaque on the same edge.
  - iniciar edge -> OCIOSO (abort). Abort drops enable_ataque, which clears the manager.
- VALIDA (1 clock):
  - col>4 or row>6 -> erro pulse, back to AGUARDA, no attempt consumed.
  - Cell already in the attacked mask -> erro pulse, back to AGUARDA, no attempt consumed.
  - Otherwise -> ATACA and set the mask bit.
- ATACA:
  - confirmar_ataque=1 for exactly PULSO_CICLOS clocks.
  - colAtaque/linAtaque stay stable for one clock before, during, and one clock after the pulse.
  - Then -> AVALIA.
- AVALIA (1 clock):
  - Hit = map bit at the captured cell. Hit -> acertos+1.
  - tentativas-1 (see optional feature).
  - Next state, in priority order: acertos==total_alvos after update -> VITORIA; else tentativas==0 after update -> DERROTA; else AGUARDA.
  - A hit on the final attempt that completes the board -> VITORIA (win has priority).
- VITORIA/DERROTA:
  - Corresponding flag held at 1; enable_ataque stays 1 so the board remains visible.
  - confirmar is ignored. iniciar edge -> OCIOSO, which clears the flags.
- Simultaneous events and counter limits:
  - In AGUARDA, iniciar and confirmar edges in the same clock -> iniciar wins; no shot.
  - Edges arriving in any state other than AGUARDA, VITORIA or DERROTA are dropped; they are not queued.
  - tentativas never wraps below 0. acertos saturates at 63.
- Reset mid-operation (any state, including mid-pulse): immediate return to the reset values; confirmar_ataque drops asynchronously.

Optional Feature:
- Macro TIRO_EXTRA_EN.
- Defined: a hit does not decrement tentativas; only misses consume attempts.
- Undefined: every accepted shot decrements tentativas by 1.

Test Plan:
- mapa0=7'b1110001, mapa1=7'b0100000, mapa4=7'b1110000, others 0; iniciar edge -> ocupado high for 35 clocks of CONTA. In AGUARDA: total_alvos=8, tentativas=15, enable_ataque=1.
- Same map, shoot (0,0) -> confirmar_ataque high exactly 2 clocks with colAtaque=0, linAtaque=0; then acertos=1, tentativas=14. Shoot (2,3) -> acertos=1, tentativas=13.
- Shoot (0,0) again -> erro pulse 1 clock, no confirmar_ataque, tentativas unchanged. Shoot (5,0) or (0,7) -> erro, nothing changed.
- MAX_TENTATIVAS=3, three misses -> derrota=1 after the third AVALIA. A further confirmar edge produces nothing. iniciar edge -> OCIOSO, enable_ataque=0, derrota=0.
- MAX_TENTATIVAS=8, hit all 8 ship cells -> vitoria=1 on the 8th AVALIA, tentativas=0, derrota=0 (win priority). With TIRO_EXTRA_EN defined: tentativas stays 8.
- Assert reset_n=0 during ATACA -> confirmar_ataque=0 immediately, state OCIOSO. All-zero map + iniciar -> vitoria=1 right after CONTA.
